// File: rtl/stack_sequencer_if.sv
// Request/response channel between the control unit (master) and the stack sequencer (slave).
interface stack_sequencer_if #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [DATA_W-1:0] req_data;
    logic              rsp_done;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W:0]   stk_cnt;

    modport master (
        output req_valid, req_op, req_data,
        input  req_ready, rsp_done, rsp_err, rsp_data, stk_cnt
    );

    modport slave (
        input  req_valid, req_op, req_data,
        output req_ready, rsp_done, rsp_err, rsp_data, stk_cnt
    );
endinterface

// File: rtl/stack_sequencer.sv
// Turns PUSH/POP/LDSP requests into stack-pointer strobes and scratch RAM accesses, tracking
// occupancy and rejecting overflow, underflow and illegal ops without side effects.
module stack_sequencer #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    stack_sequencer_if.slave  bus,
    input  logic [ADDR_W-1:0] sp_in,
    output logic              sp_ld,
    output logic [ADDR_W-1:0] sp_ld_data,
    output logic              sp_incr,
    output logic              sp_decr,
    output logic [ADDR_W-1:0] scr_addr,
    output logic              scr_we,
    output logic [DATA_W-1:0] scr_wdata,
    input  logic [DATA_W-1:0] scr_rdata
);
    localparam int unsigned    CntW     = ADDR_W + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
    localparam logic [1:0]     OpPush   = 2'b00;
    localparam logic [1:0]     OpPop    = 2'b01;
    localparam logic [1:0]     OpLdsp   = 2'b10;

    typedef enum logic [2:0] {
        StIdle, StPushWr, StPopRd, StPopCap, StLdSp, StErr
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              accept;

    assign accept = bus.req_valid && (state_q == StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            rsp_data_q <= '0;
            cnt_q      <= '0;
        end else begin
            if (accept) begin
                data_q <= bus.req_data;
            end
            if (state_q == StPopCap) begin
                rsp_data_q <= scr_rdata;
            end
            cnt_q <= cnt_d;
        end
    end

    // Full/empty decisions are made at accept time so error paths never touch SP or RAM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    case (bus.req_op)
                        OpPush:  state_d = (cnt_q == DepthCnt) ? StErr : StPushWr;
                        OpPop:   state_d = (cnt_q == '0) ? StErr : StPopRd;
                        OpLdsp:  state_d = StLdSp;
                        default: state_d = StErr;
                    endcase
                end
            end
            StPopRd: state_d = StPopCap;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case (state_q)
            StPushWr: cnt_d = cnt_q + CntW'(1);
            StPopRd:  cnt_d = cnt_q - CntW'(1);
            StLdSp:   cnt_d = '0;
            default:  cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_done  = 1'b0;
        bus.rsp_err   = 1'b0;
        bus.rsp_data  = rsp_data_q;
        bus.stk_cnt   = cnt_q;
        sp_ld         = 1'b0;
        sp_ld_data    = '0;
        sp_incr       = 1'b0;
        sp_decr       = 1'b0;
        scr_addr      = '0;
        scr_we        = 1'b0;
        scr_wdata     = '0;
        unique case (state_q)
            StIdle: bus.req_ready = 1'b1;
            StPushWr: begin
                // Stack grows downward: write below the current SP, wrapping at zero.
                scr_addr     = sp_in - ADDR_W'(1);
                scr_we       = 1'b1;
                scr_wdata    = data_q;
                sp_decr      = 1'b1;
                bus.rsp_done = 1'b1;
            end
            StPopRd: begin
                scr_addr = sp_in;
                sp_incr  = 1'b1;
            end
            StPopCap: bus.rsp_done = 1'b1;
            StLdSp: begin
                sp_ld        = 1'b1;
                sp_ld_data   = data_q[ADDR_W-1:0];
                bus.rsp_done = 1'b1;
            end
            StErr: begin
                bus.rsp_done = 1'b1;
                bus.rsp_err  = 1'b1;
            end
            default: bus.req_ready = 1'b0;
        endcase
    end
endmodule
